ast_string_collector: RTL and testbench
=======================================

// Module: ast_string_collector
// PURPOSE
//  Consumer of the strings mux's Avalon-ST output. Reassembles each AST packet (one candidate string) into a
//  parallel byte vector plus length, ready for the Bloom hash stage.
//  Drops packets whose length is outside [MIN_STR_SIZE..MAX_STR_SIZE]. Single clock domain (mux source clock).
// PARAMETERS
//  BYTE_W           8   bits per symbol
//  MIN_STR_SIZE     6   shortest accepted string, bytes
//  MAX_STR_SIZE     20  longest accepted string, bytes (<=32)
//  AST_SINK_SYMBOLS 1   symbols per AST beat
//  AST_SINK_ORDER   1   1: symbol [SYMBOLS-1] is earliest byte in beat; 0: symbol [0] is earliest
//  AST_SINK_EMPTY_W derived  1 if SYMBOLS==1 else $clog2(SYMBOLS)
//  LEN_W            derived  $clog2(MAX_STR_SIZE+1)
// PORTS
//  clk_i                    in   1                    clock
//  arst_n_i                 in   1                    reset, asynchronous, active-low
//  ast_sink_data_i          in   SYMBOLS*BYTE_W       AST data
//  ast_sink_ready_o         out  1                    AST ready
//  ast_sink_valid_i         in   1                    AST valid
//  ast_sink_empty_i         in   AST_SINK_EMPTY_W     unused symbols in eop beat (latest positions)
//  ast_sink_startofpacket_i in   1                    first beat
//  ast_sink_endofpacket_i   in   1                    last beat
//  str_data_o               out  MAX_STR_SIZE*BYTE_W  [0]=first byte; bytes >= str_len_o are 0
//  str_len_o                out  LEN_W                string length, bytes
//  str_valid_o              out  1                    string valid
//  str_ready_i              in   1                    downstream ready
// BEHAVIOUR
//  Reset: state IDLE, byte count 0, buffer 0, str_valid_o=0, str_len_o=0, str_data_o=0; ast_sink_ready_o=0 while arst_n_i low.
//  Beat accepted = valid_i && ready_o. ready_o=1 in IDLE/COLLECT/DROP, 0 in OUTPUT.
//  Beat byte count k = SYMBOLS, or SYMBOLS-empty_i on eop beat; bytes written at buffer[cnt..cnt+k-1] in stream order.
//  IDLE: beat without sop discarded. sop beat: cnt<=k, write buffer; sop&&eop -> length check.
//  COLLECT: cnt+k > MAX_STR_SIZE -> DROP (or IDLE if eop). eop -> length check.
//   sop -> discard partial; restart from this beat.
//  Length check on eop: MIN<=len<=MAX -> OUTPUT, else IDLE (dropped).
//  DROP: swallow beats until eop -> IDLE; sop -> restart as in COLLECT.
//  OUTPUT: str_valid_o=1; data/len stable until str_ready_i; handshake -> IDLE, clear buffer.
//   str_valid_o rises cycle after eop beat accepted.
//  Throughput: one string per (beats+1) cycles minimum.
//  Reset mid-packet: partial data lost, no output; next sop starts clean.
// CONFIGURATION
//  STR_COLLECTOR_DROP_CNT_EN defined: adds output drop_cnt_o [15:0]; +1 per discarded packet (short, long,
//   restarted by sop); saturates at 16'hFFFF; reset 0.
//  Undefined: port and counter absent; drops silent.
// STRUCTURE
//  bloom_strings_pkg: collector_state_t {IDLE,COLLECT,DROP,OUTPUT}; len_w() function; MAX_STR_SIZE<=32 bound constant.
//  Sub-module ast_beat_unpack (combinational): applies AST_SINK_ORDER and empty_i; emits stream-ordered byte
//   vector plus count k.
//  Collector owns FSM, buffer, counters.
// TESTING
//  SYMBOLS=1, "ABCDEF" 6 beats -> one cycle after eop: str_valid_o=1, str_len_o=6, str_data_o[0]='A', [5]='F', [6..19]=0.
//  SYMBOLS=4 ORDER=1, "ABCDEFG" 2 beats, empty=1 on eop -> str_len_o=7, bytes A..G in order; ORDER=0 same result with reversed symbols.
//  5-byte packet -> no str_valid_o; drop_cnt_o=1 (macro on).
//  25-byte packet -> DROP, no output; following 8-byte packet output with len 8.
//  str_ready_i low 10 cycles in OUTPUT -> str_data_o/len stable, ast_sink_ready_o=0; str_ready_i=1 -> IDLE next cycle.
//  arst_n_i low mid-COLLECT (3 of 10 bytes) -> all outputs 0; next 6-byte packet output correctly.

Source files
------------

// File: rtl/bloom_strings_pkg.sv
// Shared types and helpers for the Bloom-filter string path.
// Holds the collector FSM state type, the length-width helper and the
// upper bound on the collected string size.
package bloom_strings_pkg;

   // Largest string the collector buffer is ever built for
   localparam int MAX_STR_BOUND = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DROP    = 2'd2,
      ST_OUTPUT  = 2'd3
   } collector_state_t;

   // Bits needed to hold a length in 0..max_len
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/ast_beat_unpack.sv
// Combinational AST beat unpacker.
// Reorders the symbols of one beat into stream order (stream byte 0 in the
// low byte lane) and reports how many bytes of the beat are valid. Lanes
// past the valid count are forced to zero. With a single symbol per beat
// the empty field carries no information and is ignored.
module ast_beat_unpack #(
   parameter int BYTE_W  = 8,
   parameter int SYMBOLS = 1,
   parameter int ORDER   = 1,
   parameter int EMPTY_W = 1,
   parameter int CNT_W   = 1
) (
   input  logic [SYMBOLS*BYTE_W-1:0] beat_data,
   input  logic [EMPTY_W-1:0]        beat_empty,
   input  logic                      beat_eop,
   output logic [SYMBOLS*BYTE_W-1:0] stream_bytes,
   output logic [CNT_W-1:0]          byte_count
);

   // Valid byte count and stream-ordered, masked byte lanes
   always_comb begin
      stream_bytes = {(SYMBOLS*BYTE_W){1'b0}};
      if (beat_eop && (SYMBOLS > 1)) begin
         byte_count = CNT_W'(SYMBOLS) - CNT_W'(beat_empty);
      end else begin
         byte_count = CNT_W'(SYMBOLS);
      end
      for (int i = 0; i < SYMBOLS; i++) begin
         stream_bytes[i*BYTE_W +: BYTE_W] =
            (CNT_W'(i) >= byte_count) ? {BYTE_W{1'b0}} :
            (ORDER != 0)              ? beat_data[(SYMBOLS-1-i)*BYTE_W +: BYTE_W] :
                                        beat_data[i*BYTE_W +: BYTE_W];
      end
   end

endmodule

// File: rtl/ast_string_collector.sv
// Avalon-ST string collector.
// Reassembles each AST packet into a parallel byte vector (byte 0 first,
// unused bytes zero) plus length, and hands it downstream with a
// valid/ready handshake. Packets shorter than MIN_STR_SIZE or longer than
// MAX_STR_SIZE are discarded.
// Optional build macro STR_COLLECTOR_DROP_CNT_EN adds drop_cnt_o, a
// saturating count of discarded packets (short, long, or cut off by a new sop).
module ast_string_collector
   import bloom_strings_pkg::*;
#(
   parameter int BYTE_W           = 8,
   parameter int MIN_STR_SIZE     = 6,
   parameter int MAX_STR_SIZE     = 20,
   parameter int AST_SINK_SYMBOLS = 1,
   parameter int AST_SINK_ORDER   = 1,
   parameter int AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
   parameter int LEN_W            = len_w(MAX_STR_SIZE)
) (
   input  logic                               clk_i,
   input  logic                               arst_n_i,
   input  logic [AST_SINK_SYMBOLS*BYTE_W-1:0] ast_sink_data_i,
   output logic                               ast_sink_ready_o,
   input  logic                               ast_sink_valid_i,
   input  logic [AST_SINK_EMPTY_W-1:0]        ast_sink_empty_i,
   input  logic                               ast_sink_startofpacket_i,
   input  logic                               ast_sink_endofpacket_i,
   output logic [MAX_STR_SIZE*BYTE_W-1:0]     str_data_o,
   output logic [LEN_W-1:0]                   str_len_o,
   output logic                               str_valid_o,
   input  logic                               str_ready_i
`ifdef STR_COLLECTOR_DROP_CNT_EN
   ,
   output logic [15:0]                        drop_cnt_o
`endif
);

   localparam int K_W   = $clog2(AST_SINK_SYMBOLS + 1);
   localparam int SUM_W = $clog2(MAX_STR_SIZE + AST_SINK_SYMBOLS + 1);

   if (MAX_STR_SIZE > MAX_STR_BOUND) begin : g_max_size_check
      $error("MAX_STR_SIZE exceeds MAX_STR_BOUND");
   end

   collector_state_t                   state_r, state_next;
   logic [LEN_W-1:0]                   cnt_r, cnt_next;
   logic [MAX_STR_SIZE*BYTE_W-1:0]     buf_r, buf_next;
   logic                               valid_r, valid_next;
   logic                               ready_r;
   logic [AST_SINK_SYMBOLS*BYTE_W-1:0] beat_bytes;
   logic [K_W-1:0]                     beat_k;
   logic                               accept, sop, eop, takes_beat;
   logic [SUM_W-1:0]                   base_cnt, sum_cnt;

   ast_beat_unpack #(
      .BYTE_W  (BYTE_W),
      .SYMBOLS (AST_SINK_SYMBOLS),
      .ORDER   (AST_SINK_ORDER),
      .EMPTY_W (AST_SINK_EMPTY_W),
      .CNT_W   (K_W)
   ) u_unpack (
      .beat_data    (ast_sink_data_i),
      .beat_empty   (ast_sink_empty_i),
      .beat_eop     (ast_sink_endofpacket_i),
      .stream_bytes (beat_bytes),
      .byte_count   (beat_k)
   );

   assign sop        = ast_sink_startofpacket_i;
   assign eop        = ast_sink_endofpacket_i;
   assign accept     = ast_sink_valid_i && ready_r;
   // A beat carries string bytes when it opens a packet or continues one
   assign takes_beat = accept && (sop || (state_r == ST_COLLECT));
   // A sop beat always restarts at offset 0, discarding any partial string
   assign base_cnt   = sop ? {SUM_W{1'b0}} : SUM_W'(cnt_r);
   assign sum_cnt    = base_cnt + SUM_W'(beat_k);

   // Next-state, fill count, buffer and output-valid decode
   always_comb begin
      state_next = state_r;
      cnt_next   = cnt_r;
      buf_next   = buf_r;
      valid_next = valid_r;
      case (state_r)
         ST_IDLE, ST_COLLECT, ST_DROP: begin
            if (takes_beat) begin
               if (sum_cnt > SUM_W'(MAX_STR_SIZE)) begin
                  // Too long: swallow the rest of the packet
                  state_next = eop ? ST_IDLE : ST_DROP;
                  cnt_next   = {LEN_W{1'b0}};
                  buf_next   = {(MAX_STR_SIZE*BYTE_W){1'b0}};
               end else begin
                  buf_next = sop ? {(MAX_STR_SIZE*BYTE_W){1'b0}} : buf_r;
                  for (int j = 0; j < MAX_STR_SIZE; j++) begin
                     for (int i = 0; i < AST_SINK_SYMBOLS; i++) begin
                        buf_next[j*BYTE_W +: BYTE_W] =
                           ((K_W'(i) < beat_k) && ((base_cnt + SUM_W'(i)) == SUM_W'(j))) ?
                           beat_bytes[i*BYTE_W +: BYTE_W] : buf_next[j*BYTE_W +: BYTE_W];
                     end
                  end
                  cnt_next = LEN_W'(sum_cnt);
                  if (!eop) begin
                     state_next = ST_COLLECT;
                  end else if (sum_cnt < SUM_W'(MIN_STR_SIZE)) begin
                     state_next = ST_IDLE;
                     cnt_next   = {LEN_W{1'b0}};
                     buf_next   = {(MAX_STR_SIZE*BYTE_W){1'b0}};
                  end else begin
                     state_next = ST_OUTPUT;
                     valid_next = 1'b1;
                  end
               end
            end else if (accept && eop && (state_r == ST_DROP)) begin
               state_next = ST_IDLE;
            end else begin
               state_next = state_r;
            end
         end
         ST_OUTPUT: begin
            if (str_ready_i) begin
               state_next = ST_IDLE;
               valid_next = 1'b0;
               cnt_next   = {LEN_W{1'b0}};
               buf_next   = {(MAX_STR_SIZE*BYTE_W){1'b0}};
            end else begin
               state_next = ST_OUTPUT;
            end
         end
         default: begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
            cnt_next   = {LEN_W{1'b0}};
            buf_next   = {(MAX_STR_SIZE*BYTE_W){1'b0}};
         end
      endcase
   end

   // State, buffer and registered handshake outputs
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= {LEN_W{1'b0}};
         buf_r   <= {(MAX_STR_SIZE*BYTE_W){1'b0}};
         valid_r <= 1'b0;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_next;
         cnt_r   <= cnt_next;
         buf_r   <= buf_next;
         valid_r <= valid_next;
         ready_r <= (state_next != ST_OUTPUT);
      end
   end

   assign ast_sink_ready_o = ready_r;
   assign str_data_o       = buf_r;
   assign str_len_o        = cnt_r;
   assign str_valid_o      = valid_r;

`ifdef STR_COLLECTOR_DROP_CNT_EN
   logic        restart_drop, length_drop;
   logic [15:0] drop_cnt_r;
   logic [16:0] drop_sum;

   // A sop during COLLECT and a failed length check can coincide in one beat
   assign restart_drop = accept && sop && (state_r == ST_COLLECT);
   assign length_drop  = takes_beat && ((sum_cnt > SUM_W'(MAX_STR_SIZE)) ||
                                        (eop && (sum_cnt < SUM_W'(MIN_STR_SIZE))));
   assign drop_sum     = {1'b0, drop_cnt_r} + 17'(restart_drop) + 17'(length_drop);

   // Saturating discarded-packet counter
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         drop_cnt_r <= 16'h0000;
      end else begin
         drop_cnt_r <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   assign drop_cnt_o = drop_cnt_r;
`endif

endmodule

// File: tb/tb_ast_string_collector.sv
// Self-checking bench for ast_string_collector: one single-symbol instance
// and two four-symbol instances (both symbol orders) driven in lockstep.
// Expected strings come from a packet-level model: a packet that starts
// with sop and ends with eop is output iff its byte count is in [6..20].
module tb_ast_string_collector;
   localparam int MIN_LEN = 6;
   localparam int MAX_LEN = 20;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int exp_drop1 = 0, exp_drop4 = 0;
   int max_gap = 2, max_hold = 3;
   int cyc = 0;
   logic [7:0] pkt_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   logic         v1, sop1, eop1, srdy1, rdy1, sv1;
   logic [7:0]   d1;
   logic [0:0]   e1;
   logic [159:0] sd1;
   logic [4:0]   sl1;
   logic         v4, sop4, eop4, srdy4, rdy4a, rdy4b, sv4a, sv4b;
   logic [31:0]  d4a, d4b;
   logic [1:0]   e4;
   logic [159:0] sd4a, sd4b;
   logic [4:0]   sl4a, sl4b;
`ifdef STR_COLLECTOR_DROP_CNT_EN
   logic [15:0]  dc1, dc4a, dc4b;
`endif

   ast_string_collector #(.AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1)) dut1 (
      .clk_i(clk), .arst_n_i(rst_n), .ast_sink_data_i(d1), .ast_sink_ready_o(rdy1),
      .ast_sink_valid_i(v1), .ast_sink_empty_i(e1), .ast_sink_startofpacket_i(sop1),
      .ast_sink_endofpacket_i(eop1), .str_data_o(sd1), .str_len_o(sl1), .str_valid_o(sv1),
      .str_ready_i(srdy1)
`ifdef STR_COLLECTOR_DROP_CNT_EN
      , .drop_cnt_o(dc1)
`endif
   );
   ast_string_collector #(.AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(1)) dut4a (
      .clk_i(clk), .arst_n_i(rst_n), .ast_sink_data_i(d4a), .ast_sink_ready_o(rdy4a),
      .ast_sink_valid_i(v4), .ast_sink_empty_i(e4), .ast_sink_startofpacket_i(sop4),
      .ast_sink_endofpacket_i(eop4), .str_data_o(sd4a), .str_len_o(sl4a), .str_valid_o(sv4a),
      .str_ready_i(srdy4)
`ifdef STR_COLLECTOR_DROP_CNT_EN
      , .drop_cnt_o(dc4a)
`endif
   );
   ast_string_collector #(.AST_SINK_SYMBOLS(4), .AST_SINK_ORDER(0)) dut4b (
      .clk_i(clk), .arst_n_i(rst_n), .ast_sink_data_i(d4b), .ast_sink_ready_o(rdy4b),
      .ast_sink_valid_i(v4), .ast_sink_empty_i(e4), .ast_sink_startofpacket_i(sop4),
      .ast_sink_endofpacket_i(eop4), .str_data_o(sd4b), .str_len_o(sl4b), .str_valid_o(sv4b),
      .str_ready_i(srdy4)
`ifdef STR_COLLECTOR_DROP_CNT_EN
      , .drop_cnt_o(dc4b)
`endif
   );

   task automatic make_random(input int n);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic make_text(input int n, input logic [7:0] first);
      pkt_q.delete();
      for (int i = 0; i < n; i++) pkt_q.push_back(first + 8'(i));
   endtask

   function automatic logic [159:0] exp_vec();
      logic [159:0] v = 160'd0;
      for (int i = 0; i < pkt_q.size(); i++) v[i*8 +: 8] = pkt_q[i];
      return v;
   endfunction

   function automatic bit is_kept();
      return (pkt_q.size() >= MIN_LEN) && (pkt_q.size() <= MAX_LEN);
   endfunction

   task automatic check_drop(input string name);
`ifdef STR_COLLECTOR_DROP_CNT_EN
      checks++;
      if (dc1 !== 16'(exp_drop1) || dc4a !== 16'(exp_drop4) || dc4b !== 16'(exp_drop4)) begin
         failures++;
         $display("FAIL %s_drop_cnt got %0d/%0d/%0d expected %0d/%0d/%0d", name, dc1, dc4a, dc4b,
                  exp_drop1, exp_drop4, exp_drop4);
      end
`else
      if (name.len() < 0) $display("%s", name);
`endif
   endtask

   task automatic send1(input bit with_eop);
      for (int idx = 0; idx < pkt_q.size(); idx++) begin
         int gap, tries;
         bit acc;
         gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            v1 = 1'b0; d1 = 8'($urandom); @(negedge clk);
         end
         v1 = 1'b1; d1 = pkt_q[idx]; e1 = 1'($urandom);
         sop1 = (idx == 0); eop1 = with_eop && (idx == pkt_q.size() - 1);
         acc = 1'b0; tries = 0;
         while (!acc && tries < 40) begin
            acc = rdy1; tries++; @(negedge clk);
         end
         if (!acc) begin
            checks++; failures++;
            $display("FAIL send1_accept beat %0d never accepted, ready=%0b required 1", idx, rdy1);
         end
      end
      v1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0;
   endtask

   task automatic garbage1(input int n);
      for (int k = 0; k < n; k++) begin
         int tries = 0;
         bit acc = 1'b0;
         v1 = 1'b1; d1 = 8'($urandom); sop1 = 1'b0; eop1 = 1'($urandom);
         while (!acc && tries < 40) begin
            acc = rdy1; tries++; @(negedge clk);
         end
         if (!acc) begin
            checks++; failures++;
            $display("FAIL garbage_accept ready=%0b required 1", rdy1);
         end
      end
      v1 = 1'b0; eop1 = 1'b0;
   endtask

   task automatic expect1(input string name);
      if (is_kept()) begin
         logic [159:0] ev;
         int hold;
         bit stable;
         ev = exp_vec();
         checks++;
         if (sv1 !== 1'b1 || sl1 !== 5'(pkt_q.size()) || sd1 !== ev || rdy1 !== 1'b0) begin
            failures++;
            $display("FAIL %s_out got valid=%0b len=%0d rdy=%0b data=%h expected valid=1 len=%0d rdy=0 data=%h",
                     name, sv1, sl1, rdy1, sd1, pkt_q.size(), ev);
         end
         hold = $urandom_range(0, max_hold); stable = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (sv1 !== 1'b1 || sl1 !== 5'(pkt_q.size()) || sd1 !== ev || rdy1 !== 1'b0) stable = 1'b0;
         end
         checks++;
         if (!stable) begin
            failures++;
            $display("FAIL %s_hold output changed while stalled: valid=%0b len=%0d expected valid=1 len=%0d",
                     name, sv1, sl1, pkt_q.size());
         end
         srdy1 = 1'b1; @(negedge clk); srdy1 = 1'b0;
         checks++;
         if (sv1 !== 1'b0 || rdy1 !== 1'b1 || sl1 !== 5'd0 || sd1 !== 160'd0) begin
            failures++;
            $display("FAIL %s_release got valid=%0b rdy=%0b len=%0d expected valid=0 rdy=1 len=0 data=0",
                     name, sv1, rdy1, sl1);
         end
      end else begin
         bit quiet = 1'b1;
         exp_drop1++;
         for (int c = 0; c < 3; c++) begin
            if (sv1 !== 1'b0) quiet = 1'b0;
            @(negedge clk);
         end
         checks++;
         if (!quiet) begin
            failures++;
            $display("FAIL %s_dropped len=%0d raised valid, got 1 expected 0", name, pkt_q.size());
         end
      end
      check_drop(name);
   endtask

   task automatic send4(input bit with_eop);
      int n, nb;
      n = pkt_q.size(); nb = (n + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         int gap, tries;
         bit acc;
         logic [7:0] byt;
         gap = $urandom_range(0, max_gap);
         for (int g = 0; g < gap; g++) begin
            v4 = 1'b0; @(negedge clk);
         end
         for (int s = 0; s < 4; s++) begin
            if (b * 4 + s < n) byt = pkt_q[b*4+s];
            else byt = 8'($urandom);
            d4a[(3-s)*8 +: 8] = byt;
            d4b[s*8 +: 8] = byt;
         end
         v4 = 1'b1; sop4 = (b == 0); eop4 = with_eop && (b == nb - 1);
         e4 = eop4 ? 2'(nb * 4 - n) : 2'($urandom);
         acc = 1'b0; tries = 0;
         while (!acc && tries < 40) begin
            acc = rdy4a && rdy4b; tries++; @(negedge clk);
         end
         if (!acc) begin
            checks++; failures++;
            $display("FAIL send4_accept beat %0d ready=%0b/%0b required 1/1", b, rdy4a, rdy4b);
         end
      end
      v4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0;
   endtask

   task automatic expect4(input string name);
      if (is_kept()) begin
         logic [159:0] ev;
         int hold;
         ev = exp_vec();
         hold = $urandom_range(0, max_hold);
         for (int h = 0; h <= hold; h++) begin
            checks++;
            if (sv4a !== 1'b1 || sv4b !== 1'b1 || sl4a !== 5'(pkt_q.size()) || sl4b !== 5'(pkt_q.size()) ||
                sd4a !== ev || sd4b !== ev || rdy4a !== 1'b0) begin
               failures++;
               $display("FAIL %s_out cycle %0d got valid=%0b/%0b len=%0d/%0d data=%h/%h expected len=%0d data=%h",
                        name, h, sv4a, sv4b, sl4a, sl4b, sd4a, sd4b, pkt_q.size(), ev);
            end
            if (h < hold) @(negedge clk);
         end
         srdy4 = 1'b1; @(negedge clk); srdy4 = 1'b0;
         checks++;
         if (sv4a !== 1'b0 || sv4b !== 1'b0 || rdy4a !== 1'b1 || sd4a !== 160'd0 || sl4b !== 5'd0) begin
            failures++;
            $display("FAIL %s_release got valid=%0b/%0b rdy=%0b expected valid=0/0 rdy=1", name, sv4a, sv4b, rdy4a);
         end
      end else begin
         bit quiet = 1'b1;
         exp_drop4++;
         for (int c = 0; c < 3; c++) begin
            if (sv4a !== 1'b0 || sv4b !== 1'b0) quiet = 1'b0;
            @(negedge clk);
         end
         checks++;
         if (!quiet) begin
            failures++;
            $display("FAIL %s_dropped len=%0d raised valid, expected 0", name, pkt_q.size());
         end
      end
      check_drop(name);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b0 || sv1 !== 1'b0 || sl1 !== 5'd0 || sd1 !== 160'd0 ||
          rdy4a !== 1'b0 || sv4a !== 1'b0 || sd4b !== 160'd0) begin
         failures++;
         $display("FAIL reset_state got rdy=%0b valid=%0b len=%0d expected all 0", rdy1, sv1, sl1);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b1 || rdy4a !== 1'b1 || rdy4b !== 1'b1 || sv1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_release got rdy=%0b/%0b/%0b valid=%0b expected 1/1/1 and 0", rdy1, rdy4a, rdy4b, sv1);
      end
      check_drop("reset");
   endtask

   task automatic test_abcdef();
      make_text(6, 8'h41); send1(1'b1); expect1("abcdef");
   endtask

   task automatic test_length_bounds();
      int lens[6] = '{5, 6, 20, 21, 25, 8};
      foreach (lens[i]) begin
         make_random(lens[i]); send1(1'b1); expect1($sformatf("len%0d", lens[i]));
      end
   endtask

   task automatic test_backpressure();
      bit stable = 1'b1;
      logic [159:0] ev;
      make_text(7, 8'h61); ev = exp_vec();
      send1(1'b1);
      // Offer a new packet while stalled; it must not be taken
      v1 = 1'b1; sop1 = 1'b1; eop1 = 1'b1; d1 = 8'h5A;
      for (int h = 0; h < 10; h++) begin
         if (sv1 !== 1'b1 || sl1 !== 5'd7 || sd1 !== ev || rdy1 !== 1'b0) stable = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL backpressure_hold got valid=%0b len=%0d rdy=%0b expected valid=1 len=7 rdy=0", sv1, sl1, rdy1);
      end
      srdy1 = 1'b1; @(negedge clk);
      srdy1 = 1'b0; v1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0;
      checks++;
      if (sv1 !== 1'b0 || rdy1 !== 1'b1 || sd1 !== 160'd0) begin
         failures++;
         $display("FAIL backpressure_release got valid=%0b rdy=%0b expected valid=0 rdy=1", sv1, rdy1);
      end
   endtask

   task automatic test_restart();
      make_random(4); send1(1'b0); exp_drop1++;
      make_random(9); send1(1'b1); expect1("restart_short_partial");
      make_random(23); send1(1'b0); exp_drop1++;
      make_random(7); send1(1'b1); expect1("restart_from_drop");
      garbage1(5);
      make_random(12); send1(1'b1); expect1("after_garbage");
      make_random(5); send1(1'b0); exp_drop1++;
      make_random(1); send1(1'b1); expect1("restart_single_short");
   endtask

   task automatic test_mid_reset();
      make_random(3); send1(1'b0);
      rst_n = 1'b0; #1;
      checks++;
      if (rdy1 !== 1'b0 || sv1 !== 1'b0 || sl1 !== 5'd0 || sd1 !== 160'd0) begin
         failures++;
         $display("FAIL mid_reset got rdy=%0b valid=%0b len=%0d data=%h expected all 0", rdy1, sv1, sl1, sd1);
      end
      exp_drop1 = 0; exp_drop4 = 0;
      check_drop("mid_reset");
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      make_random(6); send1(1'b1); expect1("after_reset");
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int r = $urandom_range(0, 9);
         if (r < 2) garbage1($urandom_range(1, 3));
         if (r == 2 || r == 3) begin
            make_random($urandom_range(1, 24)); send1(1'b0); exp_drop1++;
         end
         make_random($urandom_range(1, 26)); send1(1'b1); expect1("rand1");
      end
   endtask

   task automatic test_sym4();
      make_text(7, 8'h41); send4(1'b1); expect4("sym4_abcdefg");
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            make_random($urandom_range(1, 24)); send4(1'b0); exp_drop4++;
         end
         make_random($urandom_range(1, 28)); send4(1'b1); expect4("rand4");
      end
   endtask

   task automatic test_back_to_back();
      int t0, budget = 0;
      max_gap = 0; max_hold = 0;
      t0 = cyc;
      for (int p = 0; p < 5; p++) begin
         make_random($urandom_range(MIN_LEN, MAX_LEN));
         budget += pkt_q.size() + 1;
         send1(1'b1); expect1("b2b");
      end
      checks++;
      if (cyc - t0 !== budget) begin
         failures++;
         $display("FAIL b2b_throughput got %0d cycles expected %0d", cyc - t0, budget);
      end
      max_gap = 2; max_hold = 3;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      v1 = 1'b0; d1 = 8'd0; e1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0; srdy1 = 1'b0;
      v4 = 1'b0; d4a = 32'd0; d4b = 32'd0; e4 = 2'd0; sop4 = 1'b0; eop4 = 1'b0; srdy4 = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_abcdef();
      test_length_bounds();
      test_backpressure();
      test_restart();
      test_mid_reset();
      test_random();
      test_sym4();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
